// File: rtl/mem_resp_stage_pkg.sv
// Shared constants for the MEM response stage: bus widths, bus field offsets, load opcodes, state encoding.
package mem_resp_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 75;
  localparam int MS_TO_WS_BUS_WD = 71;

  localparam int ES_WAIT_DATA = 74;
  localparam int ES_LD_OP_HI  = 73;
  localparam int ES_LD_OP_LO  = 71;
  localparam int ES_GR_WE     = 70;
  localparam int ES_DEST_HI   = 69;
  localparam int ES_DEST_LO   = 65;
  localparam int ES_ALU_HI    = 64;
  localparam int ES_ALU_LO    = 33;
  localparam int ES_PC_HI     = 32;
  localparam int ES_PC_LO     = 1;
  localparam int ES_IS_EXC    = 0;

  localparam logic [2:0] LD_OP_W  = 3'b000;
  localparam logic [2:0] LD_OP_B  = 3'b001;
  localparam logic [2:0] LD_OP_BU = 3'b010;
  localparam logic [2:0] LD_OP_H  = 3'b011;
  localparam logic [2:0] LD_OP_HU = 3'b100;

  localparam logic [1:0] STATE_EMPTY = 2'd0;
  localparam logic [1:0] STATE_WAIT  = 2'd1;
  localparam logic [1:0] STATE_READY = 2'd2;

endpackage

// File: rtl/mem_resp_stage_load_extend.sv
// Combinational byte/half selection and sign/zero extension of a load response word.
module load_extend
  import mem_resp_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = rdata[7:0];
    case (addr_lo)
      2'd0:    byte_val = rdata[7:0];
      2'd1:    byte_val = rdata[15:8];
      2'd2:    byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
    half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (ld_op)
      LD_OP_W:  result = rdata;
      LD_OP_B:  result = {{24{byte_val[7]}}, byte_val};
      LD_OP_BU: result = {24'd0, byte_val};
      LD_OP_H:  result = {{16{half_val[15]}}, half_val};
      LD_OP_HU: result = {16'd0, half_val};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MEM pipeline stage: collects load responses, extends load data and hands bundles to WB.
// Optional MS_DATA_BUF_EN adds a 1-entry rdata buffer for responses arriving while WB is stalled.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ms_flush,
  output logic [4:0]                 ms_to_ds_dest,
  output logic [31:0]                ms_to_ds_result,
  output logic                       ms_to_ds_ld_busy
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic [1:0]                 state;
  logic                       discard;
  logic                       buf_valid;
  logic                       data_ok_eff;
  logic                       ms_ready_go;
  logic                       handoff;
  logic [31:0]                ld_src;
  logic [31:0]                ld_result;
  logic [31:0]                final_result;
  logic                       ws_gr_we;

  logic        wait_data;
  logic [2:0]  ld_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_res;
  logic [31:0] pc;
  logic        is_exc;

  assign wait_data = es_bus_r[ES_WAIT_DATA];
  assign ld_op     = es_bus_r[ES_LD_OP_HI:ES_LD_OP_LO];
  assign gr_we     = es_bus_r[ES_GR_WE];
  assign dest      = es_bus_r[ES_DEST_HI:ES_DEST_LO];
  assign alu_res   = es_bus_r[ES_ALU_HI:ES_ALU_LO];
  assign pc        = es_bus_r[ES_PC_HI:ES_PC_LO];
  assign is_exc    = es_bus_r[ES_IS_EXC];

  assign data_ok_eff    = data_sram_data_ok && !discard;
  assign ms_ready_go    = !wait_data || data_ok_eff || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
  assign handoff        = ms_to_ws_valid && ws_allowin;

`ifdef MS_DATA_BUF_EN
  logic [31:0] buf_rdata;

  // A response that arrives while WB is stalled is parked here until the handoff.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid <= 1'b0;
      buf_rdata <= 32'd0;
    end else if (ms_flush || handoff) begin
      buf_valid <= 1'b0;
    end else if (state == STATE_WAIT && data_ok_eff && !ws_allowin) begin
      buf_valid <= 1'b1;
      buf_rdata <= data_sram_rdata;
    end
  end

  assign ld_src = buf_valid ? buf_rdata : data_sram_rdata;
`else
  assign buf_valid = 1'b0;
  assign ld_src    = data_sram_rdata;
`endif

  load_extend u_load_extend (
    .ld_op   (ld_op),
    .addr_lo (alu_res[1:0]),
    .rdata   (ld_src),
    .result  (ld_result)
  );

  assign final_result = wait_data ? ld_result : alu_res;
  assign ws_gr_we     = gr_we && !is_exc;

  assign ms_to_ws_bus     = {ws_gr_we, dest, final_result, pc, is_exc};
  assign ms_to_ds_dest    = (ms_valid && ws_gr_we) ? dest : 5'd0;
  assign ms_to_ds_result  = final_result;
  assign ms_to_ds_ld_busy = ms_valid && wait_data && !data_ok_eff && !buf_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
      es_bus_r <= '0;
    end else if (ms_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        es_bus_r <= es_to_ms_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= STATE_EMPTY;
    end else if (ms_flush) begin
      state <= STATE_EMPTY;
    end else if (ms_allowin) begin
      if (es_to_ms_valid) begin
        state <= es_to_ms_bus[ES_WAIT_DATA] ? STATE_WAIT : STATE_READY;
      end else begin
        state <= STATE_EMPTY;
      end
    end else if (state == STATE_WAIT && data_ok_eff) begin
      state <= STATE_READY;
    end
  end

  // A request still in flight at flush time returns later; that one response must be dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      discard <= 1'b0;
    end else if (ms_flush && state == STATE_WAIT && !data_sram_data_ok) begin
      discard <= 1'b1;
    end else if (discard && data_sram_data_ok) begin
      discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_resp_stage.sv
// Scoreboard bench for mem_resp_stage: directed bundles push expected WB buses, a monitor pops on handoff.
module tb_mem_resp_stage;
  import mem_resp_stage_pkg::*;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [70:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_flush;
  logic [4:0]  ms_to_ds_dest;
  logic [31:0] ms_to_ds_result;
  logic        ms_to_ds_ld_busy;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [70:0] exp_q[$];
  int          handoff_log[$];
  logic [70:0] mon_exp;

  mem_resp_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_flush          (ms_flush),
    .ms_to_ds_dest     (ms_to_ds_dest),
    .ms_to_ds_result   (ms_to_ds_result),
    .ms_to_ds_ld_busy  (ms_to_ds_ld_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [74:0] mk_es(input logic wd, input logic [2:0] op, input logic we,
                                        input logic [4:0] d, input logic [31:0] alu,
                                        input logic [31:0] pc, input logic exc);
    return {wd, op, we, d, alu, pc, exc};
  endfunction

  function automatic logic [70:0] mk_ws(input logic we, input logic [4:0] d, input logic [31:0] res,
                                        input logic [31:0] pc, input logic exc);
    return {we, d, res, pc, exc};
  endfunction

  task automatic checkOutput(input string name, input logic [70:0] actual, input logic [70:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Holds the bundle until MEM accepts it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [74:0] bus);
    logic accepted;
    int   n;
    accepted = 1'b0;
    n = 0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    while (!accepted && n < 50) begin
      @(negedge clk);
      accepted = ms_allowin;
      @(posedge clk);
      #1;
      n++;
    end
    es_to_ms_valid = 1'b0;
    checkOutput("accept", 71'(accepted), 71'(1));
  endtask

  always @(negedge clk) begin
    if (resetn && ms_to_ws_valid && ws_allowin) begin
      handoff_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_handoff: got bus 0x%0h with empty scoreboard", ms_to_ws_bus);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("ws_bus", ms_to_ws_bus, mon_exp);
      end
    end
  end

`ifndef MS_DATA_BUF_EN
  always @(negedge clk) begin
    if (resetn && data_sram_data_ok && !ws_allowin) begin
      errors++;
      $display("[TB] FAIL no_buf_stall: data_ok with ws_allowin=0 at cycle %0d", cyc);
    end
  end
`endif

  initial begin
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    ms_flush          = 1'b0;

    stepCycle();
    stepCycle();
    checkOutput("rst_allowin", 71'(ms_allowin), 71'(1));
    checkOutput("rst_ws_valid", 71'(ms_to_ws_valid), 71'(0));
    checkOutput("rst_ws_bus", ms_to_ws_bus, 71'(0));
    checkOutput("rst_ds_dest", 71'(ms_to_ds_dest), 71'(0));
    checkOutput("rst_ds_result", 71'(ms_to_ds_result), 71'(0));
    checkOutput("rst_ld_busy", 71'(ms_to_ds_ld_busy), 71'(0));
    resetn = 1'b1;
    stepCycle();

    $display("[TB] test 1: add r4");
    exp_q.push_back(mk_ws(1'b1, 5'd4, 32'h1234, 32'h100, 1'b0));
    applyStimulus(mk_es(1'b0, LD_OP_W, 1'b1, 5'd4, 32'h1234, 32'h100, 1'b0));
    checkOutput("t1_ds_dest", 71'(ms_to_ds_dest), 71'(4));
    checkOutput("t1_ds_result", 71'(ms_to_ds_result), 71'(32'h1234));
    stepCycle();
    stepCycle();

    $display("[TB] test 2: ld.b with 3-cycle latency");
    exp_q.push_back(mk_ws(1'b1, 5'd5, 32'hFFFFFF80, 32'h104, 1'b0));
    applyStimulus(mk_es(1'b1, LD_OP_B, 1'b1, 5'd5, 32'h1002, 32'h104, 1'b0));
    checkOutput("t2_ds_dest", 71'(ms_to_ds_dest), 71'(5));
    for (int i = 0; i < 3; i++) begin
      checkOutput("t2_ld_busy", 71'(ms_to_ds_ld_busy), 71'(1));
      stepCycle();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h00800000;
    #1;
    checkOutput("t2_busy_clear", 71'(ms_to_ds_ld_busy), 71'(0));
    stepCycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    stepCycle();

    $display("[TB] test 3: ld.hu with WB stall");
    exp_q.push_back(mk_ws(1'b1, 5'd6, 32'h0000BEEF, 32'h108, 1'b0));
    applyStimulus(mk_es(1'b1, LD_OP_HU, 1'b1, 5'd6, 32'h2002, 32'h108, 1'b0));
    stepCycle();
`ifdef MS_DATA_BUF_EN
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF0000;
    stepCycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h12345678;
    #1;
    checkOutput("t3_buf_valid", 71'(ms_to_ws_valid), 71'(1));
    checkOutput("t3_buf_result", 71'(ms_to_ds_result), 71'(32'h0000BEEF));
    checkOutput("t3_buf_busy", 71'(ms_to_ds_ld_busy), 71'(0));
    stepCycle();
    ws_allowin = 1'b1;
    stepCycle();
`else
    ws_allowin = 1'b0;
    stepCycle();
    checkOutput("t3_stall_valid", 71'(ms_to_ws_valid), 71'(0));
    checkOutput("t3_stall_busy", 71'(ms_to_ds_ld_busy), 71'(1));
    stepCycle();
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF0000;
    stepCycle();
    data_sram_data_ok = 1'b0;
`endif
    data_sram_rdata = 32'd0;
    stepCycle();

    $display("[TB] test 4: flush during WAIT, stale response dropped");
    applyStimulus(mk_es(1'b1, LD_OP_W, 1'b1, 5'd7, 32'h3000, 32'h10C, 1'b0));
    ms_flush = 1'b1;
    stepCycle();
    ms_flush = 1'b0;
    #1;
    checkOutput("t4_flush_allowin", 71'(ms_allowin), 71'(1));
    checkOutput("t4_flush_busy", 71'(ms_to_ds_ld_busy), 71'(0));
    exp_q.push_back(mk_ws(1'b1, 5'd8, 32'h0000CAFE, 32'h110, 1'b0));
    applyStimulus(mk_es(1'b1, LD_OP_W, 1'b1, 5'd8, 32'h3004, 32'h110, 1'b0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000DEAD;
    #1;
    checkOutput("t4_stale_busy", 71'(ms_to_ds_ld_busy), 71'(1));
    checkOutput("t4_stale_valid", 71'(ms_to_ws_valid), 71'(0));
    stepCycle();
    data_sram_data_ok = 1'b0;
    stepCycle();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000CAFE;
    stepCycle();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    stepCycle();
    stepCycle();

    $display("[TB] test 5: back-to-back add/ld.w/add");
    handoff_log.delete();
    exp_q.push_back(mk_ws(1'b1, 5'd9, 32'h11, 32'h200, 1'b0));
    exp_q.push_back(mk_ws(1'b1, 5'd10, 32'h55AA, 32'h204, 1'b0));
    exp_q.push_back(mk_ws(1'b1, 5'd11, 32'h22, 32'h208, 1'b0));
    applyStimulus(mk_es(1'b0, LD_OP_W, 1'b1, 5'd9, 32'h11, 32'h200, 1'b0));
    applyStimulus(mk_es(1'b1, LD_OP_W, 1'b1, 5'd10, 32'h4000, 32'h204, 1'b0));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h55AA;
    applyStimulus(mk_es(1'b0, LD_OP_W, 1'b1, 5'd11, 32'h22, 32'h208, 1'b0));
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    stepCycle();
    stepCycle();
    checkOutput("t5_handoffs", 71'(handoff_log.size()), 71'(3));
    if (handoff_log.size() == 3) begin
      checkOutput("t5_gap_1", 71'(handoff_log[1] - handoff_log[0]), 71'(1));
      checkOutput("t5_gap_2", 71'(handoff_log[2] - handoff_log[1]), 71'(1));
    end

    $display("[TB] test 6: exception bundle");
    exp_q.push_back(mk_ws(1'b0, 5'd12, 32'h5000, 32'h300, 1'b1));
    applyStimulus(mk_es(1'b0, LD_OP_W, 1'b1, 5'd12, 32'h5000, 32'h300, 1'b1));
    checkOutput("t6_ds_dest", 71'(ms_to_ds_dest), 71'(0));
    stepCycle();
    stepCycle();
    stepCycle();

    checkOutput("scoreboard_empty", 71'(exp_q.size()), 71'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
